sram_port_arb: RTL
==================

// Module: sram_port_arb
// PURPOSE
//  Shares one single-port 16Kx32 SRAM (1-cycle read latency, one word-wide write enable)
//  between the instruction-fetch port (IFU) and the load/store port (LSU).
//  LSU has fixed priority; an age counter bounds IFU starvation.
//  Sub-word stores become read-modify-write sequences, because the SRAM has no byte enables.
//  Sits between the core's IFU/LSU and the SRAM wrapper.
// PARAMETERS
//  IFU_MAX_WAIT  4  consecutive cycles IFU may be refused (req high, no gnt) before it wins over LSU
//  CNT_W         3  width of the IFU wait counter; must hold IFU_MAX_WAIT
// PORTS
//  clk_i         in   1   clock, all state on rising edge
//  rst_n_i       in   1   asynchronous active-low reset
//  ifu_req_i     in   1   IFU read request; held with addr until ifu_gnt_o
//  ifu_addr_i    in   32  IFU byte address (word = [15:2])
//  ifu_gnt_o     out  1   IFU request accepted this cycle (combinational)
//  ifu_rvalid_o  out  1   IFU read data valid (one cycle after gnt)
//  ifu_rdata_o   out  32  IFU read data, meaningful only with ifu_rvalid_o
//  lsu_req_i     in   1   LSU request; held with all fields until lsu_gnt_o
//  lsu_we_i      in   1   1 = store, 0 = load
//  lsu_be_i      in   4   store byte enables, bit n -> bits [8n+7:8n]; ignored for loads
//  lsu_addr_i    in   32  LSU byte address (word = [15:2])
//  lsu_wdata_i   in   32  store data, byte-lane aligned
//  lsu_gnt_o     out  1   LSU request accepted this cycle (combinational)
//  lsu_rvalid_o  out  1   LSU load data valid (one cycle after gnt; never asserted for stores)
//  lsu_rdata_o   out  32  LSU load data, meaningful only with lsu_rvalid_o
//  mem_en_o      out  1   SRAM enable
//  mem_wen_o     out  1   SRAM write enable (full word)
//  mem_addr_o    out  32  SRAM byte address
//  mem_wdata_o   out  32  SRAM write data
//  mem_rdata_i   in   32  SRAM read data, valid the cycle after a read enable
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, wait counter 0, rvalid flags 0.
//   Reset mid-RMW drops the pending write; the SRAM word is left unchanged.
//  FSM IDLE (accepting requests), RMW_WR (merge-write cycle, no grants).
//  Arbitration in IDLE:
//   - IFU wins if the counter has reached IFU_MAX_WAIT; otherwise LSU wins. Exactly one gnt per cycle.
//  Counter:
//   - increments (saturating) each cycle ifu_req_i=1 and ifu_gnt_o=0;
//   - resets to 0 on ifu_gnt_o or when ifu_req_i=0.
//  Granted read (IFU, or LSU with we=0):
//   - mem_en_o=1, mem_wen_o=0, mem_addr_o=addr;
//   - next cycle: the requester's rvalid=1 and rdata=mem_rdata_i (passthrough).
//  Full store (be=4'hF):
//   - mem_en_o=1, mem_wen_o=1, wdata=lsu_wdata_i; completes in the grant cycle; stay IDLE.
//  Partial store (be != 0, != F):
//   - grant cycle issues a SRAM read of addr and captures addr/be/wdata; go to RMW_WR.
//   - RMW_WR cycle: mem_en_o=mem_wen_o=1, same addr, wdata lane n = be[n] ? saved wdata : mem_rdata_i;
//     both gnt=0; return to IDLE.
//  Empty store (be=0): granted, no SRAM access (mem_en_o=0), no rvalid.
//  Throughput: 1 op/cycle except partial stores (2 cycles).
//   - Back-to-back reads pipeline: rvalid for op N overlaps gnt for op N+1.
//  Ordering: a read granted the cycle after RMW_WR returns the merged data.
//  No requests: mem_en_o=0; mem_addr_o/mem_wdata_o are don't-care.
//  Address bits [31:16] and [1:0] are ignored by the SRAM.
//   - Misalignment is the LSU's responsibility; no error output.
// TESTING
//  1 Reset: rst_n_i low, requests high -> all outputs 0. Release: LSU read granted first edge.
//  2 Both reqs held every cycle, LSU reads -> LSU gnt 4 cycles, IFU gnt 5th, repeating.
//    Counter returns to 0 after each IFU grant.
//  3 Word 0x100 = 0xAABBCCDD; store be=4'b0101 wdata=0x11223344 -> 2-cycle sequence, no gnt in RMW_WR.
//    Then a load of 0x100 returns 0xAA22CC44.
//  4 IFU reads 0x0,0x4,0x8 back-to-back -> three gnts in consecutive cycles.
//    ifu_rvalid_o in the three following cycles with matching data.
//  5 Full store 0xDEADBEEF to 0x200, load 0x200 next cycle -> lsu_rvalid_o, 0xDEADBEEF.
//    Store with be=0 -> gnt, mem_en_o stays 0.
//  6 Assert rst_n_i during RMW_WR -> mem_wen_o drops immediately; after reset the word holds its original value.

Source files
------------

// File: rtl/sram_port_arb.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_arb
// Description : Shares one single-port 16Kx32 SRAM between the instruction
//               fetch port (IFU) and the load/store port (LSU). The LSU has
//               fixed priority. An age counter bounds how long the IFU can
//               be starved. Sub-word stores are turned into read-modify-write
//               sequences because the SRAM has no byte enables.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_port_arb #(
    parameter int IFU_MAX_WAIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    // instruction fetch port
    input  logic        ifu_req_i,
    input  logic [31:0] ifu_addr_i,
    output logic        ifu_gnt_o,
    output logic        ifu_rvalid_o,
    output logic [31:0] ifu_rdata_o,
    // load/store port
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [3:0]  lsu_be_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_gnt_o,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    // SRAM side
    output logic        mem_en_o,
    output logic        mem_wen_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [CNT_W-1:0] C_MAX_WAIT = CNT_W'(IFU_MAX_WAIT);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_RMW_WR = 1'b1
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [31:0]       r_rmw_addr;
    logic [3:0]        r_rmw_be;
    logic [31:0]       r_rmw_wdata;
    logic              r_ifu_rvalid;
    logic              r_lsu_rvalid;

    logic              w_idle;
    logic              w_ifu_wins;
    logic              w_ifu_gnt;
    logic              w_lsu_gnt;
    logic              w_lsu_full;
    logic              w_lsu_empty;
    logic              w_lsu_part;
    logic              w_rmw_active;
    logic [31:0]       w_merge;

    // Grants are only possible in IDLE and never while reset is asserted,
    // so every combinational output is forced low during reset.
    assign w_idle       = (r_state == S_IDLE) && rst_n_i;
    assign w_rmw_active = (r_state == S_RMW_WR) && rst_n_i;

    // IFU wins once it has waited long enough, or whenever LSU is silent.
    assign w_ifu_wins = ifu_req_i && ((r_wait_cnt >= C_MAX_WAIT) || !lsu_req_i);
    assign w_ifu_gnt  = w_idle && w_ifu_wins;
    assign w_lsu_gnt  = w_idle && lsu_req_i && !w_ifu_wins;

    assign w_lsu_full  = lsu_we_i && (lsu_be_i == 4'hF);
    assign w_lsu_empty = lsu_we_i && (lsu_be_i == 4'h0);
    assign w_lsu_part  = lsu_we_i && !w_lsu_full && !w_lsu_empty;

    // Byte-lane merge of the saved store data over the word read in the
    // grant cycle (which arrives on mem_rdata_i during RMW_WR).
    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign w_merge[8*g +: 8] = r_rmw_be[g] ? r_rmw_wdata[8*g +: 8]
                                               : mem_rdata_i[8*g +: 8];
    end

    assign ifu_gnt_o    = w_ifu_gnt;
    assign lsu_gnt_o    = w_lsu_gnt;
    assign ifu_rvalid_o = r_ifu_rvalid;
    assign lsu_rvalid_o = r_lsu_rvalid;
    assign ifu_rdata_o  = r_ifu_rvalid ? mem_rdata_i : 32'h0;
    assign lsu_rdata_o  = r_lsu_rvalid ? mem_rdata_i : 32'h0;

    // SRAM command: merge-write in RMW_WR, otherwise whichever port was granted.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_wen_o   = 1'b0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        if (w_rmw_active) begin
            mem_en_o    = 1'b1;
            mem_wen_o   = 1'b1;
            mem_addr_o  = r_rmw_addr;
            mem_wdata_o = w_merge;
        end else if (w_ifu_gnt) begin
            mem_en_o    = 1'b1;
            mem_addr_o  = ifu_addr_i;
        end else if (w_lsu_gnt && !w_lsu_empty) begin
            // partial stores issue a plain read here; the write follows
            mem_en_o    = 1'b1;
            mem_wen_o   = w_lsu_full;
            mem_addr_o  = lsu_addr_i;
            mem_wdata_o = w_lsu_full ? lsu_wdata_i : 32'h0;
        end
    end

    // FSM: a granted partial store captures its fields and spends one cycle in RMW_WR.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= S_IDLE;
            r_rmw_addr  <= 32'h0;
            r_rmw_be    <= 4'h0;
            r_rmw_wdata <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_lsu_gnt && w_lsu_part) begin
                        r_state     <= S_RMW_WR;
                        r_rmw_addr  <= lsu_addr_i;
                        r_rmw_be    <= lsu_be_i;
                        r_rmw_wdata <= lsu_wdata_i;
                    end
                end
                S_RMW_WR: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // IFU age counter: counts refused cycles, saturating, cleared on grant or idle request.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wait_cnt <= '0;
        end else if (ifu_req_i && !w_ifu_gnt) begin
            if (r_wait_cnt < C_MAX_WAIT) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // Read-data valid flags trail the read grant by one cycle (stores never return data).
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ifu_rvalid <= 1'b0;
            r_lsu_rvalid <= 1'b0;
        end else begin
            r_ifu_rvalid <= w_ifu_gnt;
            r_lsu_rvalid <= w_lsu_gnt && !lsu_we_i;
        end
    end

endmodule
`default_nettype wire
